// File: rtl/sar_ctrl_mc.sv
// sar_ctrl_mc: multi-channel successive-approximation ADC controller.
// Drives the analog mux, sample/hold switch and DAC trial code. It
// resolves one bit per cycle from the comparator and reports each finished
// code with a one-cycle end-of-conversion pulse. A conversion covers either
// one channel or every channel in turn (scan mode).
module sar_ctrl_mc #(
  parameter  int WIDTH      = 8,   // SAR resolution, 2..16
  parameter  int CHANNELS   = 4,   // analog mux channels, 1..16
  parameter  int SAMPLE_CYC = 2,   // sample-phase length, 1..15
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             scan_i,
  input  logic [CW-1:0]    ch_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] dac_o,
  output logic [CW-1:0]    mux_o,
  output logic             sample_o,
  output logic [WIDTH-1:0] result_o,
  output logic [CW-1:0]    result_ch_o,
  output logic             eoc_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int KW = $clog2(WIDTH);
  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  localparam logic [KW-1:0] K_TOP     = KW'(WIDTH - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
  localparam logic [31:0]   NUM_CH    = 32'(CHANNELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             scan_q, scan_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [SW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    result_ch_q, result_ch_d;
  logic             err_q, err_d;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      scan_q      <= 1'b0;
      ch_q        <= '0;
      samp_cnt_q  <= '0;
      k_q         <= '0;
      trial_q     <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      ch_q        <= ch_d;
      samp_cnt_q  <= samp_cnt_d;
      k_q         <= k_d;
      trial_q     <= trial_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: sequencing, bit resolution and result capture.
  // NOTE: every variable gets a hold/default value first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    ch_d        = ch_q;
    samp_cnt_d  = samp_cnt_q;
    k_d         = k_q;
    trial_d     = trial_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (scan_i) begin
            scan_d     = 1'b1;
            ch_d       = '0;
            samp_cnt_d = '0;
            state_d    = SAMPLE;
          end else if ({{(32-CW){1'b0}}, ch_i} < NUM_CH) begin
            scan_d     = 1'b0;
            ch_d       = ch_i;
            samp_cnt_d = '0;
            state_d    = SAMPLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SAMPLE: begin
        if (samp_cnt_q == SAMP_LAST) begin
          // Last sample cycle: seed the search with the MSB set.
          trial_d = '0;
          trial_d[WIDTH-1] = 1'b1;
          k_d     = K_TOP;
          state_d = CONVERT;
        end else begin
          samp_cnt_d = samp_cnt_q + SW'(1);
        end
      end

      CONVERT: begin
        // Comparator high keeps the trial bit, low clears it.
        trial_d[k_q] = cmp_i;
        if (k_q != '0) begin
          trial_d[k_q - KW'(1)] = 1'b1;
          k_d = k_q - KW'(1);
        end else begin
          // Result registers change on entry so they are valid while eoc_o is high.
          result_d    = trial_d;
          result_ch_d = ch_q;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (scan_q && (ch_q != LAST_CH)) begin
          ch_d       = ch_q + CW'(1);
          samp_cnt_d = '0;
          state_d    = SAMPLE;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort wins over every other transition and leaves the results untouched.
    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      ch_d        = ch_q;
      result_d    = result_q;
      result_ch_d = result_ch_q;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    dac_o       = (state_q == CONVERT) ? trial_q : '0;
    mux_o       = ch_q;
    sample_o    = (state_q == SAMPLE);
    result_o    = result_q;
    result_ch_o = result_ch_q;
    eoc_o       = (state_q == DONE);
    busy_o      = (state_q != IDLE);
    err_o       = err_q;
  end

endmodule

// File: tb/tb_sar_ctrl_mc.sv
// Directed bench for sar_ctrl_mc: an ideal comparator model answers
// Vin >= dac_o, with a per-channel Vin table indexed by mux_o.
module tb_sar_ctrl_mc;

  logic       clk;
  logic       rst_n;
  logic       start, scan, abort, cmp;
  logic [1:0] ch;
  logic [7:0] dac, result;
  logic [1:0] mux, result_ch;
  logic       sample, eoc, busy, err;

  // Second instance with three channels, used for the out-of-range request.
  logic       start2, abort2, cmp2;
  logic [1:0] ch2;
  logic [7:0] dac2, result2;
  logic [1:0] mux2, result_ch2;
  logic       sample2, eoc2, busy2, err2;

  logic [7:0] vin_tab [0:3];
  logic [7:0] dac_seen [0:7];

  int checks = 0;
  int errors = 0;

  sar_ctrl_mc #(.WIDTH(8), .CHANNELS(4), .SAMPLE_CYC(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .scan_i(scan), .ch_i(ch),
    .abort_i(abort), .cmp_i(cmp), .dac_o(dac), .mux_o(mux), .sample_o(sample),
    .result_o(result), .result_ch_o(result_ch), .eoc_o(eoc), .busy_o(busy),
    .err_o(err)
  );

  sar_ctrl_mc #(.WIDTH(8), .CHANNELS(3), .SAMPLE_CYC(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .scan_i(1'b0), .ch_i(ch2),
    .abort_i(abort2), .cmp_i(cmp2), .dac_o(dac2), .mux_o(mux2), .sample_o(sample2),
    .result_o(result2), .result_ch_o(result_ch2), .eoc_o(eoc2), .busy_o(busy2),
    .err_o(err2)
  );

  assign cmp  = (vin_tab[mux] >= dac);
  assign cmp2 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One single-channel conversion; cycle 0 is the cycle start is presented.
  task automatic run_single(input logic [1:0] c, input logic [7:0] v);
    vin_tab[c] = v;
    ch    = c;
    scan  = 1'b0;
    start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    check("s_sample1", {31'd0, sample}, 32'd1);
    check("s_mux",     {30'd0, mux},    {30'd0, c});
    check("s_dac0",    {24'd0, dac},    32'd0);
    check("s_busy",    {31'd0, busy},   32'd1);
    tick();                                   // cycle 2
    check("s_sample2", {31'd0, sample}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();                                 // cycles 3..10
      dac_seen[i] = dac;
      if (i == 0) check("s_sample_off", {31'd0, sample}, 32'd0);
    end
    check("s_eoc_early", {31'd0, eoc}, 32'd0);
    tick();                                   // cycle 11
    check("s_eoc",       {31'd0, eoc},       32'd1);
    check("s_result",    {24'd0, result},    {24'd0, v});
    check("s_result_ch", {30'd0, result_ch}, {30'd0, c});
    tick();                                   // cycle 12
    check("s_eoc_pulse", {31'd0, eoc},       32'd0);
    check("s_idle",      {31'd0, busy},      32'd0);
    check("s_hold",      {24'd0, result},    {24'd0, v});
    check("s_mux_hold",  {30'd0, mux},       {30'd0, c});
  endtask

  logic [7:0] exp_dac [0:7];

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0; scan = 1'b0; abort = 1'b0; ch = 2'd0;
    start2 = 1'b0; abort2 = 1'b0; ch2 = 2'd0;
    for (int i = 0; i < 4; i++) vin_tab[i] = 8'h00;
    exp_dac[0] = 8'h80; exp_dac[1] = 8'hC0; exp_dac[2] = 8'hA0; exp_dac[3] = 8'hB0;
    exp_dac[4] = 8'hA8; exp_dac[5] = 8'hA4; exp_dac[6] = 8'hA6; exp_dac[7] = 8'hA5;

    // Reset state
    #2;
    check("rst_dac",    {24'd0, dac},       32'd0);
    check("rst_result", {24'd0, result},    32'd0);
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_eoc",    {31'd0, eoc},       32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single channel 2, Vin = 0xA5, with the full DAC trial sequence
    run_single(2'd2, 8'hA5);
    for (int i = 0; i < 8; i++) check($sformatf("dac_seq%0d", i), {24'd0, dac_seen[i]}, {24'd0, exp_dac[i]});

    // All-ones and all-zeros extremes
    run_single(2'd1, 8'hFF);
    run_single(2'd1, 8'h00);

    // Scan of all four channels: eoc at cycles 11, 22, 33, 44
    vin_tab[0] = 8'h10; vin_tab[1] = 8'h7F; vin_tab[2] = 8'h80; vin_tab[3] = 8'hEE;
    scan  = 1'b1;
    ch    = 2'd3;
    start = 1'b1;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      tick();
      start = 1'b0;
      scan  = 1'b0;
      check($sformatf("scan_eoc_c%0d", cyc), {31'd0, eoc}, (cyc % 11 == 0) ? 32'd1 : 32'd0);
      if (cyc % 11 == 1)
        check($sformatf("scan_mux_c%0d", cyc), {30'd0, mux}, 32'(cyc / 11));
      if (cyc % 11 == 0) begin
        check($sformatf("scan_res_c%0d", cyc), {24'd0, result}, {24'd0, vin_tab[cyc / 11 - 1]});
        check($sformatf("scan_ch_c%0d", cyc),  {30'd0, result_ch}, 32'(cyc / 11 - 1));
      end
    end
    check("scan_busy_last", {31'd0, busy}, 32'd1);
    tick();
    check("scan_busy_drop", {31'd0, busy}, 32'd0);

    // Abort in CONVERT (cycle 5), with a start ignored while busy
    vin_tab[1] = 8'h33;
    ch = 2'd1; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick(); tick(); tick();                   // cycle 4
    start = 1'b1; ch = 2'd2;
    tick();                                   // cycle 5
    start = 1'b0;
    check("busy_start_err", {31'd0, err},  32'd0);
    check("busy_start_mux", {30'd0, mux},  32'd1);
    check("abort_convert",  {24'd0, dac} != 32'd0 ? 32'd1 : 32'd0, 32'd1);
    abort = 1'b1;
    tick();                                   // cycle 6
    abort = 1'b0;
    check("abort_busy",      {31'd0, busy},      32'd0);
    check("abort_dac",       {24'd0, dac},       32'd0);
    check("abort_eoc",       {31'd0, eoc},       32'd0);
    check("abort_result",    {24'd0, result},    32'hEE);
    check("abort_result_ch", {30'd0, result_ch}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_eoc", {31'd0, eoc}, 32'd0);
    end

    // Abort in IDLE has no effect; abort together with start still starts
    abort = 1'b1;
    tick();
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    vin_tab[0] = 8'h5A;
    ch = 2'd0; start = 1'b1;
    tick();                                   // cycle 1, SAMPLE
    start = 1'b0; abort = 1'b0;
    check("abort_idle_start", {31'd0, sample}, 32'd1);

    // Reset asserted during SAMPLE clears everything at once
    rst_n = 1'b0;
    #1;
    check("midrst_sample", {31'd0, sample},    32'd0);
    check("midrst_busy",   {31'd0, busy},      32'd0);
    check("midrst_mux",    {30'd0, mux},       32'd0);
    check("midrst_result", {24'd0, result},    32'd0);
    check("midrst_rch",    {30'd0, result_ch}, 32'd0);
    check("midrst_dac",    {24'd0, dac},       32'd0);
    check("midrst_eoc",    {31'd0, eoc},       32'd0);
    check("midrst_err",    {31'd0, err},       32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_single(2'd3, 8'hC3);

    // Three-channel instance: ch 3 is rejected with a one-cycle err pulse
    ch2 = 2'd3; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("err_pulse", {31'd0, err2},  32'd1);
    check("err_busy",  {31'd0, busy2}, 32'd0);
    tick();
    check("err_clear", {31'd0, err2},  32'd0);
    check("err_idle",  {31'd0, busy2}, 32'd0);
    ch2 = 2'd2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("ch2_accept", {31'd0, busy2}, 32'd1);
    check("ch2_noerr",  {31'd0, err2},  32'd0);
    check("ch2_mux",    {30'd0, mux2},  32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_ctrl_mc.md
SAR_CTRL_MC -- requirements
Module: sar_ctrl_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: SAR resolution in bits, legal 2..16.
REQ-002 SHALL have parameter CHANNELS, default 4: number of analog mux channels, legal 1..16.
REQ-003 SHALL have parameter SAMPLE_CYC, default 2: sample-phase length in cycles, legal 1..15.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1: request a conversion, sampled only in IDLE.
REQ-007 SHALL have port scan_i, input, 1: sampled with start_i; 1 = scan all channels, 0 = single channel.
REQ-008 SHALL have port ch_i, input, CW = max(1, clog2(CHANNELS)): channel for single mode.
REQ-009 SHALL have port abort_i, input, 1: abort the conversion in progress.
REQ-010 SHALL have port cmp_i, input, 1: comparator result, 1 = Vin >= Vdac.
REQ-011 SHALL have port dac_o, output, WIDTH: DAC trial code.
REQ-012 SHALL have port mux_o, output, CW: analog mux channel select.
REQ-013 SHALL have port sample_o, output, 1: sample/hold switch closed.
REQ-014 SHALL have port result_o, output, WIDTH: last completed conversion code.
REQ-015 SHALL have port result_ch_o, output, CW: channel of result_o.
REQ-016 SHALL have port eoc_o, output, 1: one-cycle end-of-conversion pulse.
REQ-017 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.
REQ-018 SHALL have port err_o, output, 1: one-cycle pulse when start_i is rejected.

Function
REQ-019 SHALL implement states IDLE, SAMPLE, CONVERT and DONE.
REQ-020 IDLE: when start_i=1 and ch_i < CHANNELS (or scan_i=1), SHALL latch mode and channel (scan starts at channel 0) and enter SAMPLE next cycle.
REQ-021 IDLE: when start_i=1, scan_i=0 and ch_i >= CHANNELS, SHALL stay in IDLE and pulse err_o for 1 cycle.
REQ-022 SAMPLE: sample_o=1 for exactly SAMPLE_CYC cycles; mux_o = latched channel; dac_o = 0; on the last SAMPLE cycle SHALL load trial = 1<<(WIDTH-1) and bit index k = WIDTH-1.
REQ-023 CONVERT: SHALL run one bit per cycle with dac_o = trial; cmp_i=0 clears bit k, cmp_i=1 keeps it; if k>0, set bit k-1 and decrement k; if k=0, go to DONE; exactly WIDTH cycles.
REQ-024 DONE: SHALL pulse eoc_o for 1 cycle, with result_o = final trial and result_ch_o = channel, both updated in that same cycle and held until the next DONE.
REQ-025 After DONE, single mode or last scan channel (CHANNELS-1) SHALL go to IDLE; otherwise increment the channel and go to SAMPLE.
REQ-026 Latency: start accepted in cycle 0 -> eoc_o high in cycle SAMPLE_CYC+WIDTH+1; a scan of N channels SHALL take N*(SAMPLE_CYC+WIDTH+1) cycles.
REQ-027 mux_o SHALL be stable from SAMPLE entry through DONE of each channel, and SHALL hold its last value in IDLE.
REQ-028 start_i while busy_o=1 SHALL be ignored, with no err_o.
REQ-029 abort_i=1 in any non-IDLE state SHALL force IDLE next cycle with no eoc_o, result_o unchanged and dac_o=0; abort_i has priority over start_i and DONE transitions.
REQ-030 abort_i in IDLE SHALL have no effect.
REQ-031 Code path SHALL handle cmp_i=1 on all bits -> all-ones result and cmp_i=0 on all bits -> zero result, with no overflow.

Reset
REQ-032 On rst_ni=0 (asynchronous), SHALL force state IDLE, dac_o=0, mux_o=0, sample_o=0, result_o=0, result_ch_o=0, eoc_o=0, busy_o=0, err_o=0.
REQ-033 Reset asserted mid-conversion SHALL discard the conversion with no eoc_o; after release, SHALL accept start_i on the first clock edge.

Verification (WIDTH=8, CHANNELS=4, SAMPLE_CYC=2, cmp_i = Vin >= dac_o)
REQ-034 Single, ch_i=2, Vin=0xA5 -> dac_o sequence 80,C0,A0,B0,A8,A4,A6,A5; eoc_o in cycle 11; result_o=0xA5, result_ch_o=2.
REQ-035 Vin=0xFF then Vin=0x00 -> result_o=0xFF then result_o=0x00.
REQ-036 Scan, Vin per channel 0x10,0x7F,0x80,0xEE -> 4 eoc_o pulses at cycles 11,22,33,44, result_ch_o 0..3 with matching codes; busy_o drops after cycle 44.
REQ-037 abort_i in CONVERT cycle 5 -> IDLE next cycle, no eoc_o, result_o keeps its prior value; start_i during busy ignored.
REQ-038 ch_i=5 is unrepresentable with CW=2, so use CHANNELS=3 with ch_i=3 -> err_o pulse, busy_o stays 0.
REQ-039 rst_ni low in SAMPLE -> all outputs 0 immediately; new start_i after release -> normal conversion.
